// File: rtl/rice_core_pkg.sv
// Shared types and helpers for the rice core CSR access path.
// Latency: n/a (types, constants and a combinational merge function only).
// Backpressure: n/a.
package rice_core_pkg;

  // CSR instruction flavour; encoding 0 is reserved and decodes as illegal
  typedef enum logic [1:0] {
    CSR_OP_RSVD = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } rice_core_csr_op;

  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_H = 2'd2,
    PRIV_M = 2'd3
  } rice_core_privilege_level;

  typedef enum logic [2:0] {
    CSR_ST_IDLE   = 3'd0,
    CSR_ST_RD_REQ = 3'd1,
    CSR_ST_RD_RSP = 3'd2,
    CSR_ST_WR_REQ = 3'd3,
    CSR_ST_WR_RSP = 3'd4,
    CSR_ST_DONE   = 3'd5
  } rice_core_csr_state;

  // address[11:10] == 2'b11 marks a read-only CSR
  localparam logic [1:0] CSR_RO_FIELD = 2'b11;
  // address[9:8] holds the lowest privilege allowed to touch the CSR
  localparam int CSR_PRIV_LSB = 8;
  // merge function works at the widest supported XLEN; callers truncate
  localparam int CSR_MERGE_W = 64;

  // New CSR value from the old value and the rs1/zimm operand
  function automatic logic [CSR_MERGE_W-1:0] rice_core_csr_merge(
    input rice_core_csr_op          op,
    input logic [CSR_MERGE_W-1:0]   old_value,
    input logic [CSR_MERGE_W-1:0]   operand
  );
    logic [CSR_MERGE_W-1:0] result;
    case (op)
      CSR_OP_RW: result = operand;
      CSR_OP_RS: result = old_value | operand;
      CSR_OP_RC: result = old_value & ~operand;
      default:   result = old_value;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/rice_bus_if.sv
// Simple request/response bus used for CSR access (non-posted writes).
// Latency: set by the slave; a response follows every accepted request.
// Backpressure: request_valid/request_ready handshake, response_ready from master.
interface rice_bus_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          request_valid;
  logic          request_ready;
  logic [AW-1:0] address;
  logic          write;
  logic [DW-1:0] write_data;
  logic          response_valid;
  logic          response_ready;
  logic [DW-1:0] read_data;
  logic          error;

  modport master (
    output request_valid, address, write, write_data, response_ready,
    input  request_ready, response_valid, read_data, error
  );

  modport slave (
    input  request_valid, address, write, write_data, response_ready,
    output request_ready, response_valid, read_data, error
  );
endinterface

// File: rtl/rice_core_csr_access.sv
// Execute-stage CSR sequencer: privilege/RO check, then read-modify-write on the CSR bus.
// Latency: 5 cycles accept->done for read+write, 3 for a single access, 1 when statically illegal.
// Backpressure: o_ready only in IDLE; bus requests hold until request_ready; response_ready tied high.
module rice_core_csr_access
  import rice_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic [1:0]      i_privilege_level,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [11:0]     i_address,
  input  logic [XLEN-1:0] i_operand,
  input  logic            i_rs1_zero,
  input  logic            i_rd_zero,
  output logic            o_done,
  output logic [XLEN-1:0] o_rd_value,
  output logic            o_illegal,
  rice_bus_if.master      csr_if
);

  rice_core_csr_state state_q, state_d;
  rice_core_csr_op    in_op;
  rice_core_csr_op    op_q;
  logic [11:0]        addr_q;
  logic [XLEN-1:0]    operand_q;
  logic [XLEN-1:0]    old_q;
  logic               write_q;
  logic               illegal_q;
  logic               flush_q;

  logic               accept;
  logic               acc_read;
  logic               acc_write;
  logic               acc_illegal;
  logic               req_hs;
  logic               rsp_hs;
  logic               flushing;

  assign in_op     = rice_core_csr_op'(i_op);
  assign accept    = (state_q == CSR_ST_IDLE) && i_valid && !i_flush;
  // CSRRW with rd=x0 must not read (no read side effects); CSRRS/C with rs1=x0 must not write
  assign acc_read  = !((in_op == CSR_OP_RW) && i_rd_zero);
  assign acc_write = (in_op == CSR_OP_RW) || !i_rs1_zero;
  assign acc_illegal = (in_op == CSR_OP_RSVD)
                    || (i_address[CSR_PRIV_LSB+1:CSR_PRIV_LSB] > i_privilege_level)
                    || ((i_address[11:10] == CSR_RO_FIELD) && acc_write);

  assign req_hs   = csr_if.request_valid && csr_if.request_ready;
  assign rsp_hs   = csr_if.response_valid && csr_if.response_ready;
  // a flush seen while a request was in flight is remembered until its response drains
  assign flushing = i_flush || flush_q;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= CSR_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: skip bus phases not needed, drain issued requests on flush
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CSR_ST_IDLE: begin
        if (accept) begin
          if (acc_illegal)    state_d = CSR_ST_DONE;
          else if (acc_read)  state_d = CSR_ST_RD_REQ;
          else if (acc_write) state_d = CSR_ST_WR_REQ;
          else                state_d = CSR_ST_DONE;
        end
      end
      CSR_ST_RD_REQ: begin
        if (req_hs)       state_d = CSR_ST_RD_RSP;
        else if (i_flush) state_d = CSR_ST_IDLE;
      end
      CSR_ST_RD_RSP: begin
        if (rsp_hs) begin
          if (flushing)                state_d = CSR_ST_IDLE;
          else if (csr_if.error)       state_d = CSR_ST_DONE;
          else if (write_q)            state_d = CSR_ST_WR_REQ;
          else                         state_d = CSR_ST_DONE;
        end
      end
      CSR_ST_WR_REQ: begin
        if (req_hs)       state_d = CSR_ST_WR_RSP;
        else if (i_flush) state_d = CSR_ST_IDLE;
      end
      CSR_ST_WR_RSP: begin
        if (rsp_hs) state_d = flushing ? CSR_ST_IDLE : CSR_ST_DONE;
      end
      CSR_ST_DONE: state_d = CSR_ST_IDLE;
      default:     state_d = CSR_ST_IDLE;
    endcase
  end

  // Outputs: bus request decoded from state, completion gated by flush
  always_comb begin
    o_ready               = accept;
    o_done                = (state_q == CSR_ST_DONE) && !i_flush;
    o_illegal             = o_done && illegal_q;
    o_rd_value            = (o_done && !illegal_q) ? old_q : '0;
    csr_if.request_valid  = (state_q == CSR_ST_RD_REQ) || (state_q == CSR_ST_WR_REQ);
    csr_if.write          = (state_q == CSR_ST_WR_REQ);
    csr_if.address        = addr_q;
    csr_if.write_data     = XLEN'(rice_core_csr_merge(op_q, CSR_MERGE_W'(old_q),
                                                      CSR_MERGE_W'(operand_q)));
    csr_if.response_ready = 1'b1;
  end

  // Instruction capture, old-value latch and exception/flush bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q      <= CSR_OP_RSVD;
      addr_q    <= '0;
      operand_q <= '0;
      old_q     <= '0;
      write_q   <= 1'b0;
      illegal_q <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= in_op;
        addr_q    <= i_address;
        operand_q <= i_operand;
        old_q     <= '0;
        write_q   <= acc_write;
        illegal_q <= acc_illegal;
        flush_q   <= 1'b0;
      end
      if ((state_q == CSR_ST_RD_RSP) && rsp_hs) begin
        old_q <= csr_if.read_data;
        if (csr_if.error) illegal_q <= 1'b1;
      end
      if ((state_q == CSR_ST_WR_RSP) && rsp_hs && csr_if.error) begin
        illegal_q <= 1'b1;
      end
      // flush racing a request handshake, or arriving while waiting for a response
      if (i_flush && (state_q != CSR_ST_IDLE) && (state_q != CSR_ST_DONE)) begin
        if (req_hs || (state_q == CSR_ST_RD_RSP) || (state_q == CSR_ST_WR_RSP)) begin
          flush_q <= 1'b1;
        end
      end
    end
  end

endmodule
